delta_accum: RTL



---
 rtl/delta_accum_if.sv | 14 +
 rtl/delta_accum.sv | 101 ++++++++++
 2 files changed

// File: rtl/delta_accum_if.sv
// dti_s_if: valid/ready stream with data and end-of-transfer marker.
// The producer drives data, dvalid and eot. The consumer drives dready.
// A transfer happens on every clock edge where dvalid and dready are both high.
interface dti_s_if #(
  parameter int W = 8
);
  logic [W-1:0] data;
  logic         dvalid;
  logic         eot;
  logic         dready;

  modport producer (output data, output dvalid, output eot, input  dready);
  modport consumer (input  data, input  dvalid, input  eot, output dready);
endinterface

// File: rtl/delta_accum.sv
// delta_accum: stream integrator that rebuilds absolute values from deltas.
//
// Each accepted delta is extended to DOUT bits and added to a running sum.
// The new sum is presented on dout through a single output register.
// A delta flagged with eot closes the frame: its sum is still emitted,
// and then the accumulator restarts from INIT.
//
// Optional feature: define DELTA_ACCUM_SAT_EN to make the result saturate
// instead of wrapping modulo 2^DOUT. The saturated value is also the value
// kept in the accumulator.
module delta_accum #(
  parameter int              DIN        = 8,
  parameter int              DIN_SIGNED = 0,
  parameter int              DOUT       = 16,
  parameter logic [DOUT-1:0] INIT       = '0
) (
  input  logic     clk,
  input  logic     rst,
  dti_s_if.consumer din,
  dti_s_if.producer dout
);

  logic [DOUT-1:0] acc_r;
  logic [DOUT-1:0] out_data_r;
  logic            out_valid_r;
  logic            out_eot_r;

  logic            sign_s;
  logic [DOUT-1:0] ext_s;
  logic [DOUT-1:0] result_s;
  logic            acc_event_s;

  // The input may move whenever the output register is empty or is being drained.
  assign din.dready  = !out_valid_r | dout.dready;
  assign acc_event_s = din.dvalid & din.dready;

  // Extend the incoming delta to accumulator width: sign fill or zero fill.
  always_comb begin
    sign_s = (DIN_SIGNED != 0) ? din.data[DIN-1] : 1'b0;
    ext_s  = {DOUT{sign_s}};
    ext_s[DIN-1:0] = din.data;
  end

`ifdef DELTA_ACCUM_SAT_EN
  localparam logic [DOUT-1:0] SMAX = {1'b0, {(DOUT-1){1'b1}}};
  localparam logic [DOUT-1:0] SMIN = {1'b1, {(DOUT-1){1'b0}}};
  localparam logic [DOUT-1:0] UMAX = {DOUT{1'b1}};

  logic [DOUT:0] sum_s;

  // Saturating add. Unsigned mode clamps on carry out. Signed mode clamps when
  // both operands have the same sign and the result sign differs from it.
  always_comb begin
    sum_s = {1'b0, acc_r} + {1'b0, ext_s};
    if (DIN_SIGNED != 0) begin
      if ((acc_r[DOUT-1] == ext_s[DOUT-1]) && (sum_s[DOUT-1] != acc_r[DOUT-1])) begin
        result_s = acc_r[DOUT-1] ? SMIN : SMAX;
      end else begin
        result_s = sum_s[DOUT-1:0];
      end
    end else begin
      if (sum_s[DOUT]) begin
        result_s = UMAX;
      end else begin
        result_s = sum_s[DOUT-1:0];
      end
    end
  end
`else
  // Plain modulo-2^DOUT add. Two's complement wrap covers the signed case as well.
  always_comb begin
    result_s = acc_r + ext_s;
  end
`endif

  // Accumulator and output register, both with synchronous reset.
  // A new acceptance takes priority over draining the output, so a
  // simultaneous handshake reloads the register without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r       <= INIT;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_eot_r   <= 1'b0;
    end else if (acc_event_s) begin
      acc_r       <= din.eot ? INIT : result_s;
      out_data_r  <= result_s;
      out_valid_r <= 1'b1;
      out_eot_r   <= din.eot;
    end else if (dout.dready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign dout.data   = out_data_r;
  assign dout.dvalid = out_valid_r;
  assign dout.eot    = out_eot_r;

endmodule
